// File: rtl/cl_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cl_timing_pkg
//  Description : Shared types and constants for the CameraLink multi-tap
//                test-timing generator: sequencer state encoding and
//                test-pattern mode codes.
//  Revision    : 1.0  initial release
// ============================================================================
package cl_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INTEG  = 3'd1,
        ST_HBLANK = 3'd2,
        ST_READ   = 3'd3,
        ST_VBLANK = 3'd4,
        ST_END    = 3'd5
    } state_t;

    localparam logic [1:0] c_MODE_FCNT  = 2'd0;  // running pixel count across the frame
    localparam logic [1:0] c_MODE_XRAMP = 2'd1;  // x coordinate
    localparam logic [1:0] c_MODE_YRAMP = 2'd2;  // y coordinate
    localparam logic [1:0] c_MODE_CONST = 2'd3;  // programmed constant

endpackage : cl_timing_pkg
`default_nettype wire

// File: rtl/cl_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cl_pattern_gen
//  Description : Registered TAPS-lane test-pattern datapath. Updates dout
//                once per READ beat; holds its last value otherwise.
//  Ports       : clk, rst_n      clock / async active-low reset
//                frame_start     high while the sequencer integrates
//                beat            high for each READ beat
//                mode, const_val pattern select and constant value
//                x, y            x of tap 0 and line index of this beat
//                dout            TAPS*DW packed pixels, tap 0 in low bits
//  Revision    : 1.0  initial release
// ============================================================================
module cl_pattern_gen
    import cl_timing_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TAPS = 2,
    parameter int CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 beat,
    input  logic [1:0]           mode,
    input  logic [DW-1:0]        const_val,
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    output logic [TAPS*DW-1:0]   dout
);

    localparam logic [DW-1:0] c_TAPS_DW = DW'(TAPS);

    // Frame-wide pixel counter: advancing by TAPS per beat across all lines
    // yields y*W + x without a multiplier, since W is a multiple of TAPS.
    logic [DW-1:0]        r_acc;
    logic [DW-1:0]        w_x;
    logic [DW-1:0]        w_y;
    logic [TAPS*DW-1:0]   w_dout_next;

    assign w_x = DW'(x);
    assign w_y = DW'(y);

    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_lane
            localparam logic [DW-1:0] c_K = DW'(k);
            assign w_dout_next[k*DW +: DW] =
                (mode == c_MODE_FCNT)  ? (r_acc + c_K) :
                (mode == c_MODE_XRAMP) ? (w_x + c_K)   :
                (mode == c_MODE_YRAMP) ? w_y           :
                                         const_val;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            dout  <= '0;
        end else begin
            if (frame_start) begin
                r_acc <= '0;
            end else if (beat) begin
                r_acc <= r_acc + c_TAPS_DW;
            end
            if (beat) begin
                dout <= w_dout_next;
            end
        end
    end

endmodule : cl_pattern_gen
`default_nettype wire

// File: rtl/cl_timing_gen_mt.sv
`default_nettype none
// ============================================================================
//  Module      : cl_timing_gen_mt
//  Description : Multi-tap CameraLink test-timing generator. Sequences
//                integration, horizontal/vertical blanking and readout and
//                emits FVAL/LVAL/DVAL with TAPS test pixels per clock.
//  Ports       : clk, rst_n          clock / async active-low reset
//                sys_en              run request (level)
//                cfg_*               geometry, blanking, integration,
//                                    pattern and framing configuration
//                busy, cfg_err       sequencer status
//                frame_valid, line_valid, data_valid   video strobes
//                dout                TAPS*DW pixels, tap 0 = lowest x
//                line_cnt, pixel_cnt coordinates aligned with dout
//                frame_cnt, frame_done  completed-frame count / pulse
//  Revision    : 1.0  initial release
// ============================================================================
module cl_timing_gen_mt
    import cl_timing_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TAPS = 2,
    parameter int CW   = 16,
    parameter int IW   = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sys_en,
    input  logic [CW-1:0]        cfg_w,
    input  logic [CW-1:0]        cfg_h,
    input  logic [CW-1:0]        cfg_hblank,
    input  logic [CW-1:0]        cfg_vblank,
    input  logic [IW-1:0]        cfg_integ,
    input  logic [1:0]           cfg_mode,
    input  logic [DW-1:0]        cfg_const,
    input  logic                 cfg_cont,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 frame_valid,
    output logic                 line_valid,
    output logic                 data_valid,
    output logic [TAPS*DW-1:0]   dout,
    output logic [CW-1:0]        line_cnt,
    output logic [CW-1:0]        pixel_cnt,
    output logic [15:0]          frame_cnt,
    output logic                 frame_done
);

    localparam int            c_TW    = (IW > CW) ? IW : CW;
    localparam int            c_TSH   = $clog2(TAPS);
    localparam logic [CW-1:0] c_TMASK = CW'(TAPS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [c_TW-1:0]   r_tmr;
    logic [c_TW-1:0]   w_tmr_load;
    logic [CW-1:0]     r_beat;
    logic [CW-1:0]     r_line;

    // Per-frame shadow copies of the configuration.
    logic [CW-1:0]     r_w;
    logic [CW-1:0]     r_h;
    logic [CW-1:0]     r_hblank;
    logic [CW-1:0]     r_vblank;
    logic [1:0]        r_mode;
    logic [DW-1:0]     r_const;
    logic              r_cont;

    logic              w_geom_ok;
    logic              w_tmr_zero;
    logic              w_last_line;
    logic              w_enter_integ;
    logic              w_err_set;
    logic              w_err_clr;

    assign w_geom_ok     = (cfg_w != '0) && (cfg_h != '0) && ((cfg_w & c_TMASK) == '0);
    assign w_tmr_zero    = (r_tmr == '0);
    assign w_last_line   = (r_line == (r_h - 1'b1));
    assign w_enter_integ = (w_next == ST_INTEG) && (r_state != ST_INTEG);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_err_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sys_en) begin
                    if (w_geom_ok) begin
                        w_next    = ST_INTEG;
                        w_err_clr = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_INTEG: begin
                if (w_tmr_zero) w_next = ST_HBLANK;
            end
            ST_HBLANK: begin
                if (w_tmr_zero) w_next = ST_READ;
            end
            ST_READ: begin
                if (w_tmr_zero) begin
                    if (!w_last_line)          w_next = ST_HBLANK;
                    else if (r_vblank == '0)   w_next = ST_END;
                    else                       w_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (w_tmr_zero) w_next = ST_END;
            end
            ST_END: begin
                // Continuous restart re-checks the live geometry because it
                // is about to be latched for the next frame.
                if (r_cont && sys_en) begin
                    if (w_geom_ok) begin
                        w_next    = ST_INTEG;
                        w_err_clr = 1'b1;
                    end else begin
                        w_next    = ST_IDLE;
                        w_err_set = 1'b1;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Down-counter holds the remaining cycles of the current state minus one;
    // it is reloaded on every state change for the state being entered.
    always_comb begin
        w_tmr_load = '0;
        case (w_next)
            ST_INTEG:  w_tmr_load = (cfg_integ == '0) ? '0 : c_TW'(cfg_integ - 1'b1);
            ST_HBLANK: w_tmr_load = (r_hblank == '0) ? '0 : c_TW'(r_hblank - 1'b1);
            ST_READ:   w_tmr_load = c_TW'((r_w >> c_TSH) - 1'b1);
            ST_VBLANK: w_tmr_load = c_TW'(r_vblank - 1'b1);
            default:   w_tmr_load = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr    <= '0;
            r_beat   <= '0;
            r_line   <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_hblank <= '0;
            r_vblank <= '0;
            r_mode   <= '0;
            r_const  <= '0;
            r_cont   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_tmr <= w_tmr_load;
            end else if (!w_tmr_zero) begin
                r_tmr <= r_tmr - 1'b1;
            end

            if ((w_next == ST_READ) && (r_state != ST_READ)) begin
                r_beat <= '0;
            end else if (r_state == ST_READ) begin
                r_beat <= r_beat + 1'b1;
            end

            if (w_enter_integ) begin
                r_line <= '0;
            end else if ((r_state == ST_READ) && (w_next != ST_READ)) begin
                r_line <= r_line + 1'b1;
            end

            if (w_enter_integ) begin
                r_w      <= cfg_w;
                r_h      <= cfg_h;
                r_hblank <= cfg_hblank;
                r_vblank <= cfg_vblank;
                r_mode   <= cfg_mode;
                r_const  <= cfg_const;
                r_cont   <= cfg_cont;
            end

            if (w_err_set) begin
                cfg_err <= 1'b1;
            end else if (w_err_clr) begin
                cfg_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, one cycle behind the sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            data_valid  <= 1'b0;
            line_cnt    <= '0;
            pixel_cnt   <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
        end else begin
            busy        <= (r_state != ST_IDLE);
            frame_valid <= (r_state == ST_HBLANK) || (r_state == ST_READ);
            line_valid  <= (r_state == ST_READ);
            data_valid  <= (r_state == ST_READ);
            frame_done  <= (r_state == ST_END);

            if (r_state == ST_INTEG) begin
                line_cnt  <= '0;
                pixel_cnt <= '0;
            end else if (r_state == ST_READ) begin
                line_cnt  <= r_line;
                pixel_cnt <= r_beat << c_TSH;
            end

            if (r_state == ST_END) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    cl_pattern_gen #(
        .DW   (DW),
        .TAPS (TAPS),
        .CW   (CW)
    ) u_pattern (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (r_state == ST_INTEG),
        .beat        (r_state == ST_READ),
        .mode        (r_mode),
        .const_val   (r_const),
        .x           (r_beat << c_TSH),
        .y           (r_line),
        .dout        (dout)
    );

endmodule : cl_timing_gen_mt
`default_nettype wire

// File: tb/tb_cl_timing_gen_mt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cl_timing_gen_mt
//  Description : Self-checking bench for cl_timing_gen_mt (TAPS=2, DW=16).
//                A frame-phase model predicts every output each cycle;
//                directed scenarios add hand-computed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cl_timing_gen_mt;

    localparam int DW = 16, TAPS = 2, CW = 16, IW = 24;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sys_en = 1'b0;
    logic [CW-1:0]       cfg_w, cfg_h, cfg_hblank, cfg_vblank;
    logic [IW-1:0]       cfg_integ;
    logic [1:0]          cfg_mode;
    logic [DW-1:0]       cfg_const;
    logic                cfg_cont;
    logic                busy, cfg_err, frame_valid, line_valid, data_valid, frame_done;
    logic [TAPS*DW-1:0]  dout;
    logic [CW-1:0]       line_cnt, pixel_cnt;
    logic [15:0]         frame_cnt;

    cl_timing_gen_mt #(.DW(DW), .TAPS(TAPS), .CW(CW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .sys_en(sys_en),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
        .cfg_integ(cfg_integ), .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_cont(cfg_cont),
        .busy(busy), .cfg_err(cfg_err), .frame_valid(frame_valid), .line_valid(line_valid),
        .data_valid(data_valid), .dout(dout), .line_cnt(line_cnt), .pixel_cnt(pixel_cnt),
        .frame_cnt(frame_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    bit chk_first_beat = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-phase model: a frame is a flat timeline of phases
    //   [integ][ (hblank + W/TAPS) x H ][vblank][end]
    // and every output is computed arithmetically from the phase.
    // ------------------------------------------------------------------
    int m_p;  // -1 = idle
    int mI, mHb, mW, mH, mV, mMode, mCont;
    logic [15:0] mConst;
    int m_L, m_q, m_y, m_r, m_b, m_F;
    logic        e_busy, e_err, e_fv, e_lv, e_fd;
    logic [15:0] e_line, e_pix, e_fcnt;
    logic [31:0] e_dout;

    function automatic bit geom_ok(input int w, input int h);
        return (w != 0) && (h != 0) && ((w % TAPS) == 0);
    endfunction

    task automatic model_latch();
        mI     = (cfg_integ == 0) ? 1 : int'(cfg_integ);
        mHb    = (cfg_hblank == 0) ? 1 : int'(cfg_hblank);
        mW     = int'(cfg_w);
        mH     = int'(cfg_h);
        mV     = int'(cfg_vblank);
        mMode  = int'(cfg_mode);
        mConst = cfg_const;
        mCont  = int'(cfg_cont);
    endtask

    function automatic logic [15:0] pix(input int k);
        case (mMode)
            0:       return 16'(m_y * mW + m_b * TAPS + k);
            1:       return 16'(m_b * TAPS + k);
            2:       return 16'(m_y);
            default: return mConst;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p = -1;
            {e_busy, e_err, e_fv, e_lv, e_fd} = '0;
            e_line = '0; e_pix = '0; e_fcnt = '0; e_dout = '0;
        end else begin
            e_busy = (m_p >= 0);
            e_fv = 1'b0; e_lv = 1'b0; e_fd = 1'b0;
            m_L = mHb + mW / TAPS;
            m_F = mI + mH * m_L + mV + 1;
            if (m_p >= 0) begin
                if (m_p < mI) begin
                    e_line = '0; e_pix = '0;
                end else begin
                    m_q = m_p - mI;
                    if (m_q < mH * m_L) begin
                        m_y = m_q / m_L;
                        m_r = m_q % m_L;
                        e_fv = 1'b1;
                        if (m_r >= mHb) begin
                            m_b    = m_r - mHb;
                            e_lv   = 1'b1;
                            e_line = 16'(m_y);
                            e_pix  = 16'(m_b * TAPS);
                            e_dout = {pix(1), pix(0)};
                        end
                    end else if (m_q - mH * m_L >= mV) begin
                        e_fd   = 1'b1;
                        e_fcnt = e_fcnt + 16'd1;
                    end
                end
            end
            // advance the phase
            if (m_p < 0) begin
                if (sys_en) begin
                    if (geom_ok(int'(cfg_w), int'(cfg_h))) begin
                        model_latch(); m_p = 0; e_err = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end else if (m_p == m_F - 1) begin
                if ((mCont != 0) && sys_en) begin
                    if (geom_ok(int'(cfg_w), int'(cfg_h))) begin
                        model_latch(); m_p = 0; e_err = 1'b0;
                    end else begin
                        m_p = -1; e_err = 1'b1;
                    end
                end else begin
                    m_p = -1;
                end
            end else begin
                m_p++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare and frame-valid shape monitor
    // ------------------------------------------------------------------
    int fv_rises, fd_count, fv_run, fv_last_len, fv_gap, fv_last_gap;
    bit fv_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            fv_rises = 0; fd_count = 0; fv_run = 0; fv_last_len = 0;
            fv_gap = 0; fv_last_gap = 0; fv_prev = 1'b0;
        end else begin
            if (cmp_en) begin
                chk("busy",        busy,        e_busy);
                chk("cfg_err",     cfg_err,     e_err);
                chk("frame_valid", frame_valid, e_fv);
                chk("line_valid",  line_valid,  e_lv);
                chk("data_valid",  data_valid,  e_lv);
                chk("line_cnt",    line_cnt,    e_line);
                chk("pixel_cnt",   pixel_cnt,   e_pix);
                chk("frame_cnt",   frame_cnt,   e_fcnt);
                chk("frame_done",  frame_done,  e_fd);
                chk("dout",        dout,        e_dout);
            end
            if (frame_valid && !fv_prev) begin
                fv_rises++;
                if (fv_rises > 1) fv_last_gap = fv_gap;
                fv_run = 0;
            end
            if (!frame_valid && fv_prev) begin
                fv_last_len = fv_run;
                fv_gap = 0;
            end
            if (frame_valid) fv_run++; else fv_gap++;
            if (frame_done) fd_count++;
            if (chk_first_beat && line_valid && line_cnt == 0 && pixel_cnt == 0)
                chk("mode0_frame_restart", dout, 32'h0001_0000);
            fv_prev = frame_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_cfg();
        cfg_w = 16'd8; cfg_h = 16'd3; cfg_hblank = 16'd2; cfg_vblank = 16'd4;
        cfg_integ = 24'd5; cfg_mode = 2'd0; cfg_const = 16'h0000; cfg_cont = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        sys_en = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_line(input int y, input string nm);
        int i;
        for (i = 0; i < 400 && !(line_valid && line_cnt == CW'(y) && pixel_cnt == 0); i++)
            @(negedge clk);
        chk(nm, (line_valid && line_cnt == CW'(y) && pixel_cnt == 0), 1);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 400 && busy; i++) @(negedge clk);
        chk(nm, busy, 0);
    endtask

    task automatic wait_fcnt(input int n, input string nm);
        int i;
        for (i = 0; i < 400 && frame_cnt != 16'(n); i++) @(negedge clk);
        chk(nm, frame_cnt, 16'(n));
    endtask

    task automatic pulse_en();
        sys_en = 1'b1;
        @(negedge clk);
        sys_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        set_cfg();
        do_reset();
        cmp_en = 1'b1;
        chk("reset_ctrl", {busy, cfg_err, frame_valid, line_valid, data_valid, frame_done}, 0);
        chk("reset_cnts", {line_cnt, pixel_cnt, frame_cnt}, 0);
        chk("reset_dout", dout, 0);

        // 1: single frame
        chk_first_beat = 1'b1;
        pulse_en();
        wait_line(1, "t1_reach_line1");
        chk("t1_line1_beat0", dout, 32'h0009_0008);
        wait_idle("t1_idle");
        chk("t1_fval_len", fv_last_len, 18);
        chk("t1_frame_done_cnt", fd_count, 1);
        chk("t1_frame_cnt", frame_cnt, 1);

        // 2: continuous, three frames
        do_reset();
        cfg_cont = 1'b1;
        sys_en = 1'b1;
        wait_fcnt(2, "t2_two_frames");
        sys_en = 1'b0;
        wait_idle("t2_idle");
        chk("t2_fval_gap", fv_last_gap, 10);
        chk("t2_frame_cnt", frame_cnt, 3);
        chk("t2_fval_rises", fv_rises, 3);
        chk_first_beat = 1'b0;

        // 3: graceful stop during line 1
        do_reset();
        cfg_cont = 1'b1;
        sys_en = 1'b1;
        wait_line(1, "t3_reach_line1");
        sys_en = 1'b0;
        wait_idle("t3_idle");
        repeat (30) @(negedge clk);
        chk("t3_frame_done_cnt", fd_count, 1);
        chk("t3_fval_rises", fv_rises, 1);
        chk("t3_busy", busy, 0);

        // 4: invalid geometry, then recovery
        do_reset();
        cfg_cont = 1'b0;
        cfg_w = 16'd7;
        sys_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_err_set", cfg_err, 1);
        chk("t4_not_busy", busy, 0);
        sys_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_fval", fv_rises, 0);
        cfg_w = 16'd8;
        sys_en = 1'b1;
        @(negedge clk);
        sys_en = 1'b0;
        chk("t4_err_clear", cfg_err, 0);
        @(negedge clk);
        wait_idle("t4_idle");
        chk("t4_frame_cnt", frame_cnt, 1);

        // 5: mode change mid-frame only takes effect next frame
        do_reset();
        set_cfg();
        cfg_mode = 2'd2;
        cfg_cont = 1'b1;
        sys_en = 1'b1;
        wait_line(1, "t5_reach_line1");
        cfg_mode = 2'd3;
        cfg_const = 16'hABCD;
        wait_line(2, "t5_reach_line2");
        chk("t5_yramp_kept", dout, 32'h0002_0002);
        wait_fcnt(1, "t5_frame1");
        sys_en = 1'b0;
        wait_idle("t5_idle");
        chk("t5_const_frame", dout, 32'hABCD_ABCD);

        // 6: async reset mid-READ
        do_reset();
        set_cfg();
        cfg_cont = 1'b1;
        sys_en = 1'b1;
        wait_line(0, "t6_reach_read");
        #2 rst_n = 1'b0;
        sys_en = 1'b0;
        #1;
        chk("t6_async_ctrl", {busy, frame_valid, line_valid, data_valid, frame_done}, 0);
        chk("t6_async_data", {dout, line_cnt, pixel_cnt}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_quiet_fval", fv_rises, 0);
        chk("t6_quiet_busy", busy, 0);
        pulse_en();
        wait_idle("t6_idle");
        chk("t6_frame_cnt", frame_cnt, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cl_timing_gen_mt
`default_nettype wire
